// File: rtl/serial_adder_nand.sv
// serial_adder_nand: bit-serial N-bit adder driving a single NAND-only full
// adder cell (full_adder_nand) one bit per clock, LSB first.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (priority over start)
//   start  request; accepted only while ready=1
//   a, b   N-bit operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) subtract request, captured on start
//   ready  high in IDLE
//   busy   high in ADD
//   done   one-cycle pulse; sum/cout valid
//   sum    N-bit result, held until the next result
//   cout   final carry-out, held with sum
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port; a - b via
// inverted b and forced carry-in of 1, cout=1 meaning no borrow).
//
// Latency: start accepted at end of cycle 0, ADD in cycles 1..N, done in
// cycle N+1, ready again in cycle N+2.

// Nine-NAND full adder cell.
module full_adder_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic n1, n2, n3, x1, n4, n5, n6;

  always_comb begin
    n1   = ~(a & b);
    n2   = ~(a & n1);
    n3   = ~(b & n1);
    x1   = ~(n2 & n3);   // a ^ b
    n4   = ~(x1 & cin);
    n5   = ~(x1 & n4);
    n6   = ~(cin & n4);
    s    = ~(n5 & n6);   // a ^ b ^ cin
    cout = ~(n1 & n4);   // a&b | cin&(a^b)
  end
endmodule

module serial_adder_nand #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sr, b_sr, sum_sr, sum_shift;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fa_s, fa_cout;
  logic           sub_eff;
  logic           last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  full_adder_nand u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CW'(N - 1));

  // Written as shift-then-overwrite so the same code holds for N=1.
  always_comb begin
    sum_shift        = sum_sr >> 1;
    sum_shift[N-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The result registers load on the final ADD edge (with the last cell
  // output merged in) so that sum/cout are already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub_eff ? ~b : b;
            carry <= sub_eff | cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= sum_shift;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_nand.sv
// Self-checking bench for serial_adder_nand (N=8): table-driven vectors plus
// hand-written sequences; results checked through an expected-result queue
// popped whenever done is seen.
module tb_serial_adder_nand;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         ready, busy, done, cout;
  logic [N-1:0] sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] es;
    logic         ec;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];

  serial_adder_nand #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] va, input logic [N-1:0] vb,
                                 input logic vc, input logic vs);
    logic [N:0] r;
    exp_t e;
    r = {1'b0, va} + {1'b0, (vs ? ~vb : vb)} + {{N{1'b0}}, (vs ? 1'b1 : vc)};
    e.s = r[N-1:0];
    e.c = r[N];
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", {24'b0, sum}, {24'b0, e.s});
        check("cout", {31'b0, cout}, {31'b0, e.c});
      end
    end
  end

  // Called #1 after a clock edge with the DUT ready. Returns #1 after the
  // edge that starts cycle N+2 (ready again). hold keeps start high and
  // scrambles the operands while the operation is in flight.
  task automatic do_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                       input logic vs, input logic [N-1:0] es, input logic ec,
                       input bit hold);
    exp_t e;
    a = va;
    b = vb;
    cin = vc;
    sub = vs;
`ifndef SERIAL_ADDER_SUB_EN
    if (vs) $display("note: sub requested but feature not built");
`endif
    e.s = es;
    e.c = ec;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int i = 1; i <= N + 2; i++) begin
      check("done_timing", {31'b0, done}, {31'b0, (i == N + 1)});
      check("busy_timing", {31'b0, busy}, {31'b0, (i <= N)});
      check("ready_timing", {31'b0, ready}, {31'b0, (i == N + 2)});
      if (i < N + 2) begin
        if (hold) begin
          a = N'($urandom);
          b = N'($urandom);
          cin = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    vt[0] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, es: 8'h4B, ec: 1'b0};
    vt[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, es: 8'h00, ec: 1'b1};
    vt[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, es: 8'hFF, ec: 1'b1};
    vt[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, es: 8'h01, ec: 1'b0};
    vt[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, es: 8'h00, ec: 1'b1};
    vt[5] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, es: 8'hFF, ec: 1'b0};
    vt[6] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, es: 8'h00, ec: 1'b1};
    vt[7] = '{a: 8'h00, b: 8'h00, cin: 1'b0, es: 8'h00, ec: 1'b0};
    vt[8] = '{a: 8'h7F, b: 8'h01, cin: 1'b1, es: 8'h81, ec: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", {24'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);

    foreach (vt[i])
      do_op(vt[i].a, vt[i].b, vt[i].cin, 1'b0, vt[i].es, vt[i].ec, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] ra, rb;
      logic rc;
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      m = model(ra, rb, rc, 1'b0);
      do_op(ra, rb, rc, 1'b0, m.s, m.c, 1'b0);
    end

    // start held high with operands changing during the operation.
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);
    do_op(8'h21, 8'h10, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0);

    // Reset in cycle 4 of an addition.
    a = 8'h55;
    b = 8'hAA;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_ready", {31'b0, ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_sum", {24'b0, sum}, 32'd0);
    check("midrst_cout", {31'b0, cout}, 32'd0);
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", {31'b0, done}, 32'd0);
      check("midrst_idle", {31'b0, ready}, 32'd1);
    end
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = N'($urandom);
      m = model(ra, rb, 1'b0, 1'b1);
      do_op(ra, rb, 1'b0, 1'b1, m.s, m.c, 1'b0);
    end
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
